// File: rtl/fios_sched_pkg.sv
// Shared state encoding and schedule geometry for the FIOS strobe scheduler.
// All functions are constant functions evaluated at elaboration time.
package fios_sched_pkg;

    typedef enum logic [2:0] {IDLE, ROUND, DRAIN, PUSH, DONE} state_t;

    function automatic int pe_delay(input int level);
        if (level <= 1) return 5;
        else if (level == 2) return 6;
        else return 8;
    endfunction

    function automatic int pe_nb(input bit fold, input int s, input int level);
        return fold ? (2 * s + 1 + level) / pe_delay(level) + 1 : s;
    endfunction

    function automatic int num_rounds(input bit fold, input int s, input int nb);
        return fold ? (s + nb - 1) / nb : 1;
    endfunction

    function automatic int drain_lat(input int s, input int nb, input int pd);
        return ((s - 1) % nb + 1) * pd;
    endfunction

endpackage

// File: rtl/fios_sched_window.sv
// Asserts active for relative cycles [START, STOP] after a restart pulse (restart edge -> cycle 1).
// Counter saturates one past STOP so it stays quiet until the next restart.
module fios_sched_window #(
    parameter int  START = 1,
    parameter int  STOP  = 1,
    localparam int CW    = $clog2(STOP + 2)
)(
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic active
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (restart)
            cnt <= CW'(1);
        else if (cnt != '0 && cnt != CW'(STOP + 1))
            cnt <= cnt + CW'(1);
    end

    assign active = (cnt >= CW'(START)) && (cnt <= CW'(STOP));

endmodule

// File: rtl/fios_sched_ctrl.sv
// FIOS strobe scheduler: IDLE->ROUND*R->DRAIN->PUSH->DONE with ready/start handshake and a 1-deep pending slot.
// Moore strobes start the cycle after accept; ready_o is low while the slot is full. FIOS_SCHED_PERF_EN adds op/stall counters.
module fios_sched_ctrl
    import fios_sched_pkg::*;
#(
    parameter string CONFIGURATION = "EXPAND",
    parameter int    ABREG         = 1,
    parameter int    MREG          = 1,
    parameter int    s             = 8,
    localparam bit   FOLD          = (CONFIGURATION == "FOLD"),
    localparam int   DSP_REG_LEVEL = ABREG + MREG + 1,
    localparam int   PE_DELAY      = pe_delay(DSP_REG_LEVEL),
    localparam int   PE_NB         = pe_nb(FOLD, s, DSP_REG_LEVEL),
    localparam int   R             = num_rounds(FOLD, s, PE_NB),
    localparam int   L             = s + PE_DELAY,
    localparam int   RES_LAT       = drain_lat(s, PE_NB, PE_DELAY),
    localparam int   RW            = $clog2(R + 1)
)(
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          a_shift_o,
    output logic          b_fetch_o,
    output logic          p_fetch_o,
    output logic          RES_push_o,
    output logic          done_o,
    output logic [RW-1:0] round_o
`ifdef FIOS_SCHED_PERF_EN
    ,
    output logic [31:0]   op_count_o,
    output logic [31:0]   stall_cycles_o
`endif
);

    localparam int CMAX = (L > RES_LAT) ? L : RES_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] r;
    logic          pend, accept, last_cyc, round_restart, push_restart, enter;

    assign accept        = start_i & ~pend;
    assign last_cyc      = (state == ROUND) && (cnt == CW'(L));
    assign round_restart = (nxt == ROUND) && ((state != ROUND) || last_cyc);
    assign push_restart  = (nxt == PUSH) && (state != PUSH);
    assign enter         = (nxt != state) || round_restart;

    always_ff @(posedge clock_i) begin
        if (reset_i)
            state <= IDLE;
        else
            state <= nxt;
    end

    // DONE doubles as cycle 0 of the next op, either from the slot or a same-cycle start.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = ROUND;
            ROUND:   if (last_cyc && r == RW'(R - 1)) nxt = DRAIN;
            DRAIN:   if (cnt == CW'(RES_LAT)) nxt = PUSH;
            PUSH:    if (cnt == CW'(s)) nxt = DONE;
            DONE:    nxt = (pend || accept) ? ROUND : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt  <= '0;
            r    <= '0;
            pend <= 1'b0;
        end else begin
            if (nxt == IDLE)
                cnt <= '0;
            else if (enter)
                cnt <= CW'(1);
            else if (cnt != CW'(CMAX))
                cnt <= cnt + CW'(1);

            if (state != ROUND)
                r <= '0;
            else if (last_cyc && r != RW'(R - 1))
                r <= r + RW'(1);

            if (state == DONE)
                pend <= 1'b0;
            else if (accept && state != IDLE)
                pend <= 1'b1;
        end
    end

    always_comb begin
        busy_o    = (state != IDLE);
        a_shift_o = last_cyc;
        done_o    = (state == DONE);
        round_o   = (state == ROUND) ? r : '0;
    end

    assign ready_o = ~pend;

    fios_sched_window #(.START(1), .STOP(s)) u_b_fetch (
        .clk(clock_i), .rst(reset_i), .restart(round_restart), .active(b_fetch_o)
    );

    fios_sched_window #(.START(1 + DSP_REG_LEVEL), .STOP(s + DSP_REG_LEVEL)) u_p_fetch (
        .clk(clock_i), .rst(reset_i), .restart(round_restart), .active(p_fetch_o)
    );

    fios_sched_window #(.START(1), .STOP(s)) u_res_push (
        .clk(clock_i), .rst(reset_i), .restart(push_restart), .active(RES_push_o)
    );

`ifdef FIOS_SCHED_PERF_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            op_count_o     <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (state == DONE)
                op_count_o <= op_count_o + 32'd1;
            if (start_i && pend && stall_cycles_o != '1)
                stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fios_sched_ctrl.sv
// Bench for fios_sched_ctrl: three configurations checked cycle by cycle against an op-timeline model.
module tb_fios_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic start [3];
    logic rst   [3];
    logic ready [3], busy [3], ash [3], bf [3], pf [3], push [3], done [3];
    logic [0:0] rnd0, rnd2;
    logic [1:0] rnd1;
`ifdef FIOS_SCHED_PERF_EN
    logic [31:0] opc [3], stl [3];
`endif

    fios_sched_ctrl #(.CONFIGURATION("EXPAND"), .ABREG(1), .MREG(1), .s(4)) dut0 (
        .clock_i(clk), .reset_i(rst[0]), .start_i(start[0]), .ready_o(ready[0]), .busy_o(busy[0]),
        .a_shift_o(ash[0]), .b_fetch_o(bf[0]), .p_fetch_o(pf[0]), .RES_push_o(push[0]),
        .done_o(done[0]), .round_o(rnd0)
`ifdef FIOS_SCHED_PERF_EN
        , .op_count_o(opc[0]), .stall_cycles_o(stl[0])
`endif
    );

    fios_sched_ctrl #(.CONFIGURATION("FOLD"), .ABREG(1), .MREG(1), .s(8)) dut1 (
        .clock_i(clk), .reset_i(rst[1]), .start_i(start[1]), .ready_o(ready[1]), .busy_o(busy[1]),
        .a_shift_o(ash[1]), .b_fetch_o(bf[1]), .p_fetch_o(pf[1]), .RES_push_o(push[1]),
        .done_o(done[1]), .round_o(rnd1)
`ifdef FIOS_SCHED_PERF_EN
        , .op_count_o(opc[1]), .stall_cycles_o(stl[1])
`endif
    );

    fios_sched_ctrl #(.CONFIGURATION("EXPAND"), .ABREG(0), .MREG(0), .s(2)) dut2 (
        .clock_i(clk), .reset_i(rst[2]), .start_i(start[2]), .ready_o(ready[2]), .busy_o(busy[2]),
        .a_shift_o(ash[2]), .b_fetch_o(bf[2]), .p_fetch_o(pf[2]), .RES_push_o(push[2]),
        .done_o(done[2]), .round_o(rnd2)
`ifdef FIOS_SCHED_PERF_EN
        , .op_count_o(opc[2]), .stall_cycles_o(stl[2])
`endif
    );

    int n_chk = 0;
    int n_pass = 0;

    // Geometry per DUT, derived from the operand length, DSP level and configuration.
    int g_s [3], g_lv [3], g_R [3], g_L [3], g_RL [3], g_T [3];
    bit g_fold [3];

    // Model: cycle-0 time of the running op (-1 when idle) and pending flag.
    int m_cur [3];
    bit m_pend [3];

    bit stim_st [600];
    bit stim_rs [600];

    int done_at [$], ash_at [$], b_at [$];
    int n_b, n_p, n_push, first_p, first_push, n_busy, n_ready_low, stall_exp, snap_cyc;
    logic [6:0] snap;

    task automatic init_geom();
        int pd, nb;
        g_s[0] = 4; g_lv[0] = 3; g_fold[0] = 0;
        g_s[1] = 8; g_lv[1] = 3; g_fold[1] = 1;
        g_s[2] = 2; g_lv[2] = 1; g_fold[2] = 0;
        for (int d = 0; d < 3; d++) begin
            pd = (g_lv[d] == 1) ? 5 : (g_lv[d] == 2) ? 6 : 8;
            nb = g_fold[d] ? (2 * g_s[d] + 1 + g_lv[d]) / pd + 1 : g_s[d];
            g_R[d]  = g_fold[d] ? (g_s[d] + nb - 1) / nb : 1;
            g_L[d]  = g_s[d] + pd;
            g_RL[d] = ((g_s[d] - 1) % nb + 1) * pd;
            g_T[d]  = g_R[d] * g_L[d] + g_RL[d] + g_s[d] + 1;
        end
    endtask

    function automatic logic [6:0] obs(input int d);
        return {ready[d], busy[d], bf[d], pf[d], ash[d], push[d], done[d]};
    endfunction

    function automatic int obs_rnd(input int d);
        return (d == 0) ? int'(rnd0) : (d == 1) ? int'(rnd1) : int'(rnd2);
    endfunction

    // Expected {ready,busy,b,p,a,push,done} for absolute cycle n from the op timeline.
    function automatic logic [6:0] model_out(input int d, input int n, output int rexp, output bit in_round);
        logic [6:0] v;
        int k, c, rl;
        v = '0; rexp = 0; in_round = 0;
        v[6] = !m_pend[d];
        k = (m_cur[d] >= 0) ? n - m_cur[d] : 0;
        rl = g_R[d] * g_L[d];
        if (k >= 1 && k <= g_T[d]) begin
            v[5] = 1'b1;
            if (k <= rl) begin
                in_round = 1;
                rexp = (k - 1) / g_L[d];
                c = k - rexp * g_L[d];
                v[4] = (c <= g_s[d]);
                v[3] = (c >= 1 + g_lv[d]) && (c <= g_s[d] + g_lv[d]);
                v[2] = (c == g_L[d]);
            end
            v[1] = (k > rl + g_RL[d]) && (k <= rl + g_RL[d] + g_s[d]);
            v[0] = (k == g_T[d]);
        end
        return v;
    endfunction

    task automatic model_adv(input int d, input int n, input bit st, input bit rs);
        bit acc;
        if (rs) begin
            m_cur[d] = -1; m_pend[d] = 0;
            return;
        end
        acc = st && !m_pend[d];
        if (m_cur[d] >= 0 && n - m_cur[d] == g_T[d]) begin
            if (m_pend[d]) begin m_cur[d] = n; m_pend[d] = 0; end
            else if (acc) m_cur[d] = n;
            else m_cur[d] = -1;
        end else if (m_cur[d] < 0) begin
            if (acc) m_cur[d] = n;
        end else if (acc) begin
            m_pend[d] = 1;
        end
    endtask

    task automatic do_reset(input int d);
        start[d] = 1'b0; rst[d] = 1'b1;
        @(posedge clk); #1;
        rst[d] = 1'b0;
        m_cur[d] = -1; m_pend[d] = 0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 600; i++) begin stim_st[i] = 0; stim_rs[i] = 0; end
    endtask

    // Drives the stimulus tables into DUT d, checks every cycle against the model and logs events.
    task automatic run_trace(input int d, input int ncyc);
        logic [6:0] e, ob;
        int rexp;
        bit inr;
        done_at.delete(); ash_at.delete(); b_at.delete();
        n_b = 0; n_p = 0; n_push = 0; first_p = -1; first_push = -1;
        n_busy = 0; n_ready_low = 0; stall_exp = 0; snap = 'x;
        for (int n = 0; n < ncyc; n++) begin
            ob = obs(d);
            e = model_out(d, n, rexp, inr);
            n_chk++;
            if (ob !== e) $display("FAIL trace d%0d cyc%0d: got %b want %b", d, n, ob, e);
            else n_pass++;
            if (inr) begin
                n_chk++;
                if (obs_rnd(d) !== rexp) $display("FAIL round d%0d cyc%0d: got %0d want %0d", d, n, obs_rnd(d), rexp);
                else n_pass++;
            end
            if (n == snap_cyc) snap = ob;
            if (ob[0]) done_at.push_back(n);
            if (ob[2]) ash_at.push_back(n);
            if (ob[4]) begin b_at.push_back(n); n_b++; end
            if (ob[3]) begin n_p++; if (first_p < 0) first_p = n; end
            if (ob[1]) begin n_push++; if (first_push < 0) first_push = n; end
            if (ob[5]) n_busy++;
            if (!ob[6]) n_ready_low++;
            if (stim_st[n] && m_pend[d] && !stim_rs[n]) stall_exp++;
            start[d] = stim_st[n];
            rst[d] = stim_rs[n];
            model_adv(d, n, stim_st[n], stim_rs[n]);
            @(posedge clk); #1;
        end
        start[d] = 1'b0; rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin start[d] = 1'b0; rst[d] = 1'b1; end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; m_cur[d] = -1; m_pend[d] = 0;
            n_chk++;
            if (obs(d) !== 7'b1000000) $display("FAIL reset_outputs d%0d: got %b want 1000000", d, obs(d));
            else n_pass++;
        end
        n_chk++;
        if ({rnd1, rnd0, rnd2} !== 4'b0000) $display("FAIL reset_round: got %b want 0000", {rnd1, rnd0, rnd2});
        else n_pass++;
    endtask

    task automatic test_expand_single();
        int got;
        do_reset(0); clear_stim(); snap_cyc = -1;
        stim_st[0] = 1;
        run_trace(0, 60);
        got = (done_at.size() == 1) ? done_at[0] : -1;
        n_chk++; if (got !== 49) $display("FAIL single_done: got %0d want 49", got); else n_pass++;
        n_chk++; if (n_b !== 4) $display("FAIL single_bcount: got %0d want 4", n_b); else n_pass++;
        n_chk++; if (first_p !== 4) $display("FAIL single_pfirst: got %0d want 4", first_p); else n_pass++;
        got = (ash_at.size() == 1) ? ash_at[0] : -1;
        n_chk++; if (got !== 12) $display("FAIL single_ashift: got %0d want 12", got); else n_pass++;
        n_chk++; if (first_push !== 45 || n_push !== 4) $display("FAIL single_push: got %0d/%0d want 45/4", first_push, n_push); else n_pass++;
        n_chk++; if (n_busy !== 49) $display("FAIL single_busy: got %0d want 49", n_busy); else n_pass++;
    endtask

    task automatic test_fold();
        int a0, a1, a2, got;
        do_reset(1); clear_stim(); snap_cyc = -1;
        stim_st[0] = 1;
        run_trace(1, 90);
        a0 = (ash_at.size() == 3) ? ash_at[0] : -1;
        a1 = (ash_at.size() == 3) ? ash_at[1] : -1;
        a2 = (ash_at.size() == 3) ? ash_at[2] : -1;
        n_chk++; if ({a0, a1, a2} !== {32'd16, 32'd32, 32'd48}) $display("FAIL fold_ashift: got %0d,%0d,%0d want 16,32,48", a0, a1, a2); else n_pass++;
        n_chk++; if (n_b !== 24) $display("FAIL fold_bcount: got %0d want 24", n_b); else n_pass++;
        n_chk++; if (n_p !== 24) $display("FAIL fold_pcount: got %0d want 24", n_p); else n_pass++;
        n_chk++; if (first_push !== 65 || n_push !== 8) $display("FAIL fold_push: got %0d/%0d want 65/8", first_push, n_push); else n_pass++;
        got = (done_at.size() == 1) ? done_at[0] : -1;
        n_chk++; if (got !== 73) $display("FAIL fold_done: got %0d want 73", got); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d0, d1, b5;
        do_reset(0); clear_stim(); snap_cyc = -1;
        stim_st[0] = 1; stim_st[5] = 1;
        run_trace(0, 110);
        d0 = (done_at.size() == 2) ? done_at[0] : -1;
        d1 = (done_at.size() == 2) ? done_at[1] : -1;
        n_chk++; if (d0 !== 49 || d1 !== 98) $display("FAIL b2b_done: got %0d,%0d want 49,98", d0, d1); else n_pass++;
        n_chk++; if (n_ready_low !== 44) $display("FAIL b2b_ready_low: got %0d want 44", n_ready_low); else n_pass++;
        b5 = (b_at.size() == 8) ? b_at[4] : -1;
        n_chk++; if (b5 !== 50) $display("FAIL b2b_second_bfetch: got %0d want 50", b5); else n_pass++;
    endtask

    task automatic test_third_start_ignored();
        do_reset(0); clear_stim(); snap_cyc = -1;
        stim_st[0] = 1; stim_st[5] = 1;
        for (int i = 10; i <= 20; i++) stim_st[i] = 1;
        run_trace(0, 110);
        n_chk++; if (done_at.size() !== 2) $display("FAIL third_done_count: got %0d want 2", done_at.size()); else n_pass++;
`ifdef FIOS_SCHED_PERF_EN
        n_chk++; if (opc[0] !== 32'd2) $display("FAIL perf_op_count: got %0d want 2", opc[0]); else n_pass++;
        n_chk++; if (stl[0] !== 32'd11) $display("FAIL perf_stall: got %0d want 11", stl[0]); else n_pass++;
        n_chk++; if (stl[0] !== 32'(stall_exp)) $display("FAIL perf_stall_model: got %0d want %0d", stl[0], stall_exp); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int got;
        do_reset(0); clear_stim(); snap_cyc = 21;
        stim_st[0] = 1; stim_rs[20] = 1; stim_st[25] = 1;
        run_trace(0, 90);
        n_chk++; if (snap !== 7'b1000000) $display("FAIL midreset_idle: got %b want 1000000", snap); else n_pass++;
        got = (done_at.size() == 1) ? done_at[0] : -1;
        n_chk++; if (got !== 74) $display("FAIL midreset_done: got %0d want 74", got); else n_pass++;
    endtask

    task automatic test_level1_done_start();
        int d0, d1, got;
        do_reset(2); clear_stim(); snap_cyc = -1;
        stim_st[0] = 1; stim_st[20] = 1;
        run_trace(2, 50);
        n_chk++; if (first_p !== 2 || n_p !== 4) $display("FAIL l1_pfetch: got %0d/%0d want 2/4", first_p, n_p); else n_pass++;
        got = (ash_at.size() > 0) ? ash_at[0] : -1;
        n_chk++; if (got !== 7) $display("FAIL l1_ashift: got %0d want 7", got); else n_pass++;
        n_chk++; if (first_push !== 18) $display("FAIL l1_push: got %0d want 18", first_push); else n_pass++;
        d0 = (done_at.size() == 2) ? done_at[0] : -1;
        d1 = (done_at.size() == 2) ? done_at[1] : -1;
        n_chk++; if (d0 !== 20 || d1 !== 40) $display("FAIL l1_done: got %0d,%0d want 20,40", d0, d1); else n_pass++;
        n_chk++; if (n_busy !== 40) $display("FAIL l1_no_idle_gap: got %0d want 40", n_busy); else n_pass++;
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            do_reset(d); clear_stim(); snap_cyc = -1;
            for (int n = 0; n < 450; n++) begin
                stim_st[n] = ($urandom_range(0, 9) == 0);
                stim_rs[n] = ($urandom_range(0, 249) == 0);
            end
            run_trace(d, 450);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin start[d] = 1'b0; rst[d] = 1'b1; m_cur[d] = -1; m_pend[d] = 0; end
        init_geom();
        #1;
        test_reset();
        test_expand_single();
        test_fold();
        test_back_to_back();
        test_third_start_ignored();
        test_reset_mid();
        test_level1_done_start();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
